led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 22 ++
 rtl/led_sequencer_tick_gen.sv | 41 ++++
 rtl/led_sequencer.sv | 144 ++++++++++++++
 tb/tb_led_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer.
//   mode_t  : pattern mode encoding, matches the 2-bit i_mode input
//   DIR_*   : i_dir encoding for ROTATE and FILL
//   bnc_t   : BOUNCE direction state encoding
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        BNC_L = 1'b0,
        BNC_R = 1'b1
    } bnc_t;

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Prescaler for the LED sequencer. Counts enabled cycles and raises o_tick
// (combinational) in the cycle whose clock edge should take a pattern step.
//   clk      : clock
//   i_ck_rst : asynchronous active-low reset
//   i_enable : 1 = count, 0 = hold count, no tick
//   i_clear  : synchronous clear of the count, wins over i_enable, no tick
//   i_limit  : period - 1 of the currently selected period
//   o_tick   : step fires on the coming edge
module tick_gen #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             i_ck_rst,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tick
);

    logic [CNT_W-1:0] cnt_q;
    logic             at_limit;

    // >= rather than == so that shrinking the period mid-count fires at once
    // instead of running the counter round through its full range.
    assign at_limit = (cnt_q >= i_limit);
    assign o_tick   = i_enable && !i_clear && at_limit;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_enable) begin
            if (at_limit) cnt_q <= '0;
            else          cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: ROTATE, BOUNCE, FILL and BLINK patterns stepped at
// one of four selectable prescaler periods.
//   clk          : clock, all state on rising edge
//   i_ck_rst     : asynchronous active-low reset
//   i_enable     : 1 = run, 0 = hold pattern, count and bounce direction
//   i_mode       : 00 ROTATE, 01 BOUNCE, 10 FILL, 11 BLINK
//   i_dir        : 1 = right (toward bit 0), 0 = left (ROTATE/FILL only)
//   i_period_sel : selects PERIOD0..PERIOD3 clocks per step
//   o_leds       : registered LED pattern
//   o_tick       : one-cycle pulse with each pattern step
//   o_wrap       : one-cycle pulse when a step returns to the entry pattern
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS  = 4,
    parameter int CNT_W   = 27,
    parameter int PERIOD0 = 12_500_000,
    parameter int PERIOD1 = 25_000_000,
    parameter int PERIOD2 = 50_000_000,
    parameter int PERIOD3 = 100_000_000
) (
    input  logic              clk,
    input  logic              i_ck_rst,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic              i_dir,
    input  logic [1:0]        i_period_sel,
    output logic [N_LEDS-1:0] o_leds,
    output logic              o_tick,
    output logic              o_wrap
);

    localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);

    function automatic logic [N_LEDS-1:0] entry_pattern(input mode_t m);
        case (m)
            MODE_FILL:  entry_pattern = '0;
            MODE_BLINK: entry_pattern = '1;
            default:    entry_pattern = LED_ONE;
        endcase
    endfunction

    mode_t             mode_q;
    mode_t             mode_in;
    bnc_t              bnc_q, bnc_d, bnc_step;
    logic [N_LEDS-1:0] leds_q, leds_step;
    logic              tick_q, wrap_q;
    logic              mode_change;
    logic              fire;
    logic [CNT_W-1:0]  limit;

    assign mode_in     = mode_t'(i_mode);
    assign mode_change = (mode_in != mode_q);

    always_comb begin
        case (i_period_sel)
            2'd0:    limit = CNT_W'(PERIOD0 - 1);
            2'd1:    limit = CNT_W'(PERIOD1 - 1);
            2'd2:    limit = CNT_W'(PERIOD2 - 1);
            default: limit = CNT_W'(PERIOD3 - 1);
        endcase
    end

    // A mode change clears the count so the new pattern gets a full period.
    tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk      (clk),
        .i_ck_rst (i_ck_rst),
        .i_enable (i_enable),
        .i_clear  (mode_change),
        .i_limit  (limit),
        .o_tick   (fire)
    );

    // Pattern that the next step would produce in the current mode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        leds_step = leds_q;
        bnc_step  = bnc_q;
        case (mode_q)
            MODE_ROTATE: begin
                if (i_dir == DIR_RIGHT) leds_step = {leds_q[0], leds_q[N_LEDS-1:1]};
                else                    leds_step = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
            end
            MODE_BOUNCE: begin
                if (bnc_q == BNC_L) begin
                    leds_step = {leds_q[N_LEDS-2:0], 1'b0};
                    if (leds_step[N_LEDS-1]) bnc_step = BNC_R;
                end else begin
                    leds_step = {1'b0, leds_q[N_LEDS-1:1]};
                    if (leds_step[0]) bnc_step = BNC_L;
                end
            end
            MODE_FILL: begin
                if (&leds_q)                 leds_step = '0;
                else if (i_dir == DIR_RIGHT) leds_step = {1'b1, leds_q[N_LEDS-1:1]};
                else                         leds_step = {leds_q[N_LEDS-2:0], 1'b1};
            end
            default: begin
                leds_step = ~leds_q;
            end
        endcase
    end

    // Bounce direction FSM next state; a mode change re-enters heading left.
    always_comb begin
        bnc_d = bnc_q;
        if (mode_change) bnc_d = BNC_L;
        else if (fire)   bnc_d = bnc_step;
    end

    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) bnc_q <= BNC_L;
        else           bnc_q <= bnc_d;
    end

    // Pattern, mode and pulse registers. Mode change outranks a step.
    always_ff @(posedge clk or negedge i_ck_rst) begin
        if (!i_ck_rst) begin
            leds_q <= LED_ONE;
            mode_q <= MODE_ROTATE;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (mode_change) begin
                mode_q <= mode_in;
                leds_q <= entry_pattern(mode_in);
            end else if (fire) begin
                leds_q <= leds_step;
                tick_q <= 1'b1;
                wrap_q <= (leds_step == entry_pattern(mode_q));
            end
        end
    end

    assign o_leds = leds_q;
    assign o_tick = tick_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with N_LEDS=4 and periods 1,2,3,5.
module tb_led_sequencer;

    logic       clk;
    logic       i_ck_rst;
    logic       i_enable;
    logic [1:0] i_mode;
    logic       i_dir;
    logic [1:0] i_period_sel;
    logic [3:0] o_leds;
    logic       o_tick;
    logic       o_wrap;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] rot_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] bnc_exp [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] fil_exp [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};

    led_sequencer #(
        .N_LEDS  (4),
        .CNT_W   (27),
        .PERIOD0 (1),
        .PERIOD1 (2),
        .PERIOD2 (3),
        .PERIOD3 (5)
    ) dut (
        .clk          (clk),
        .i_ck_rst     (i_ck_rst),
        .i_enable     (i_enable),
        .i_mode       (i_mode),
        .i_dir        (i_dir),
        .i_period_sel (i_period_sel),
        .o_leds       (o_leds),
        .o_tick       (o_tick),
        .o_wrap       (o_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clock edges; inputs change and outputs are sampled 1ns after.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] leds, input logic tick, input logic wrap);
        vectors++;
        assert (o_leds === leds) else begin
            errors++;
            $error("FAIL %s o_leds: observed %b expected %b", tag, o_leds, leds);
        end
        vectors++;
        assert (o_tick === tick) else begin
            errors++;
            $error("FAIL %s o_tick: observed %b expected %b", tag, o_tick, tick);
        end
        vectors++;
        assert (o_wrap === wrap) else begin
            errors++;
            $error("FAIL %s o_wrap: observed %b expected %b", tag, o_wrap, wrap);
        end
    endtask

    initial begin
        i_ck_rst     = 1'b1;
        i_enable     = 1'b0;
        i_mode       = 2'b00;
        i_dir        = 1'b0;
        i_period_sel = 2'd0;
        #2 i_ck_rst = 1'b0;
        #1 check("reset_async", 4'b0001, 1'b0, 1'b0);
        cyc(2);
        check("reset_held", 4'b0001, 1'b0, 1'b0);

        // ROTATE left, period 3
        i_ck_rst     = 1'b1;
        i_enable     = 1'b1;
        i_period_sel = 2'd2;
        for (int s = 0; s < 4; s++) begin
            cyc(1);
            check("rot_gap1", rot_exp[(s + 3) % 4], 1'b0, 1'b0);
            cyc(1);
            check("rot_gap2", rot_exp[(s + 3) % 4], 1'b0, 1'b0);
            cyc(1);
            check("rot_step", rot_exp[s], 1'b1, (s == 3));
        end

        // BOUNCE, period 1, i_dir toggling each step
        i_mode       = 2'b01;
        i_period_sel = 2'd0;
        cyc(1);
        check("bnc_entry", 4'b0001, 1'b0, 1'b0);
        for (int s = 0; s < 6; s++) begin
            i_dir = ~i_dir;
            cyc(1);
            check("bnc_step", bnc_exp[s], 1'b1, (s == 5));
        end

        // FILL right, period 1
        i_mode = 2'b10;
        i_dir  = 1'b1;
        cyc(1);
        check("fill_entry", 4'b0000, 1'b0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            cyc(1);
            check("fill_step", fil_exp[s], 1'b1, (s == 4));
        end

        // ROTATE, period 5, shortened to period 1 mid-count
        i_mode       = 2'b00;
        i_dir        = 1'b0;
        i_period_sel = 2'd3;
        cyc(1);
        check("sel_entry", 4'b0001, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            cyc(1);
            check("sel_count", 4'b0001, 1'b0, 1'b0);
        end
        i_period_sel = 2'd0;
        cyc(1);
        check("sel_fast1", 4'b0010, 1'b1, 1'b0);
        cyc(1);
        check("sel_fast2", 4'b0100, 1'b1, 1'b0);

        // Build a partial count, then switch to BLINK while disabled
        i_period_sel = 2'd3;
        cyc(2);
        check("blink_precount", 4'b0100, 1'b0, 1'b0);
        i_enable     = 1'b0;
        i_mode       = 2'b11;
        i_period_sel = 2'd1;
        cyc(1);
        check("blink_entry", 4'b1111, 1'b0, 1'b0);
        cyc(1);
        check("blink_hold", 4'b1111, 1'b0, 1'b0);
        i_enable = 1'b1;
        cyc(1);
        check("blink_cnt_cleared", 4'b1111, 1'b0, 1'b0);
        cyc(1);
        check("blink_off", 4'b0000, 1'b1, 1'b0);
        cyc(1);
        check("blink_gap", 4'b0000, 1'b0, 1'b0);
        cyc(1);
        check("blink_on", 4'b1111, 1'b1, 1'b1);

        // BOUNCE hold, direction retention, then reset mid-count
        i_mode       = 2'b01;
        i_period_sel = 2'd0;
        cyc(1);
        check("hold_entry", 4'b0001, 1'b0, 1'b0);
        cyc(1);
        check("hold_pre1", 4'b0010, 1'b1, 1'b0);
        cyc(1);
        check("hold_pre2", 4'b0100, 1'b1, 1'b0);
        i_enable = 1'b0;
        for (int s = 0; s < 10; s++) begin
            cyc(1);
            check("hold_frozen", 4'b0100, 1'b0, 1'b0);
        end
        i_enable = 1'b1;
        cyc(1);
        check("hold_resume", 4'b1000, 1'b1, 1'b0);
        cyc(1);
        check("hold_turn", 4'b0100, 1'b1, 1'b0);
        i_period_sel = 2'd3;
        cyc(2);
        check("midcount", 4'b0100, 1'b0, 1'b0);
        #2 i_ck_rst = 1'b0;
        #1 check("midrst_async", 4'b0001, 1'b0, 1'b0);
        cyc(2);
        check("midrst_held", 4'b0001, 1'b0, 1'b0);

        // Release: mode register must be ROTATE, count restarted from 0
        i_ck_rst     = 1'b1;
        i_mode       = 2'b00;
        i_dir        = 1'b0;
        i_period_sel = 2'd2;
        cyc(1);
        check("rel_cyc1", 4'b0001, 1'b0, 1'b0);
        cyc(1);
        check("rel_cyc2", 4'b0001, 1'b0, 1'b0);
        cyc(1);
        check("rel_step", 4'b0010, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
